// File: rtl/ram_arb_pkg.sv
// Shared constants for the RAM port arbiter: FSM encodings, access sizes,
// RW encoding, requester ids and the size/alignment legality rule.
package ram_arb_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_GRANT  = 3'd1;
    localparam logic [2:0] ST_ACCESS = 3'd2;
    localparam logic [2:0] ST_DONE   = 3'd3;
    localparam logic [2:0] ST_ERR    = 3'd4;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

    localparam logic REQ_IF = 1'b0;
    localparam logic REQ_DS = 1'b1;

    function automatic logic size_align_ok(input logic [1:0] size, input logic [1:0] lsb);
        logic ok;
        ok = 1'b0;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~lsb[0];
            SZ_WORD: ok = (lsb == 2'b00);
            SZ_RSVD: ok = 1'b0;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ram_mfc_watchdog.sv
// MFC watchdog: counts cycles while an access is outstanding and flags
// expiry on the TIMEOUT_CYC-th counted cycle. Used only with RAM_TIMEOUT_EN.
module ram_mfc_watchdog #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic count,
    output logic expire
);

    localparam int unsigned CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt;

    assign expire = count && (cnt == LIMIT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (count) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares the single ram512x8 port between instruction fetch and data access,
// sequencing MFA/MFC. Define RAM_TIMEOUT_EN to add the MFC watchdog.
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic              ifDone,
    output logic [DATA_W-1:0] ifData,
    input  logic              dsReq,
    input  logic              dsRW,
    input  logic [ADDR_W-1:0] dsAddr,
    input  logic [1:0]        dsSize,
    input  logic [DATA_W-1:0] dsWData,
    output logic              dsDone,
    output logic [DATA_W-1:0] dsRData,
    output logic              busErr,
    output logic              ramMFA,
    output logic              ramRW,
    output logic [ADDR_W-1:0] ramAddress,
    output logic [1:0]        ramDataSize,
    output logic [DATA_W-1:0] ramDataIn,
    input  logic [DATA_W-1:0] ramDataOut,
    input  logic              ramMFC
);

    if (TIMEOUT_CYC < 2) begin : g_bad_cfg
        $error("ram_port_arbiter: TIMEOUT_CYC must be at least 2");
    end

    logic [2:0]        state;
    logic              gnt_id;
    logic              last_gnt;
    logic              pick;
    logic              any_req;
    logic              legal;
    logic              fin;
    logic              fin_err;
    logic [DATA_W-1:0] fin_data;
    logic              timeout;

    // Round-robin between the two requesters; the one granted last loses a tie.
    always_comb begin
        any_req = ifReq | dsReq;
        pick    = REQ_DS;
        if (ifReq && dsReq) begin
            pick = (last_gnt == REQ_DS) ? REQ_IF : REQ_DS;
        end else if (ifReq) begin
            pick = REQ_IF;
        end
        legal = (pick == REQ_IF) ? (ifAddr[1:0] == 2'b00)
                                 : size_align_ok(dsSize, dsAddr[1:0]);
    end

    always_comb begin
        fin      = 1'b0;
        fin_err  = 1'b0;
        fin_data = '0;
        case (state)
            ST_ACCESS: begin
                if (ramMFC) begin
                    fin      = 1'b1;
                    fin_data = (ramRW == RW_WRITE) ? '0 : ramDataOut;
                end else if (timeout) begin
                    fin     = 1'b1;
                    fin_err = 1'b1;
                end
            end
            ST_ERR: begin
                fin     = 1'b1;
                fin_err = 1'b1;
            end
            default: ;
        endcase
    end

`ifdef RAM_TIMEOUT_EN
    ram_mfc_watchdog #(
        .TIMEOUT_CYC(TIMEOUT_CYC)
    ) u_wdog (
        .clk   (Clk),
        .rst_n (reset),
        .clear (state != ST_ACCESS),
        .count (state == ST_ACCESS),
        .expire(timeout)
    );
`else
    assign timeout = 1'b0;
`endif

    always_ff @(posedge Clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            gnt_id      <= REQ_IF;
            last_gnt    <= REQ_IF;
            ifDone      <= 1'b0;
            dsDone      <= 1'b0;
            busErr      <= 1'b0;
            ifData      <= '0;
            dsRData     <= '0;
            ramMFA      <= 1'b0;
            ramRW       <= 1'b0;
            ramAddress  <= '0;
            ramDataSize <= '0;
            ramDataIn   <= '0;
        end else begin
            ifDone <= fin && (gnt_id == REQ_IF);
            dsDone <= fin && (gnt_id == REQ_DS);
            busErr <= fin_err;
            if (fin) begin
                if (gnt_id == REQ_IF) begin
                    ifData <= fin_data;
                end else begin
                    dsRData <= fin_data;
                end
            end

            case (state)
                ST_IDLE: begin
                    // Skip arbitration while a done pulse is showing so the ERR
                    // path gets the same recovery cycle as DONE.
                    if (any_req && !(ifDone || dsDone)) begin
                        gnt_id   <= pick;
                        last_gnt <= pick;
                        state    <= legal ? ST_GRANT : ST_ERR;
                    end
                end
                ST_GRANT: begin
                    if (gnt_id == REQ_IF) begin
                        ramAddress  <= ifAddr;
                        ramRW       <= RW_READ;
                        ramDataSize <= SZ_WORD;
                        ramDataIn   <= '0;
                    end else begin
                        ramAddress  <= dsAddr;
                        ramRW       <= dsRW;
                        ramDataSize <= dsSize;
                        ramDataIn   <= dsWData;
                    end
                    ramMFA <= 1'b1;
                    state  <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    if (fin) begin
                        ramMFA <= 1'b0;
                        state  <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                ST_ERR:  state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Randomized self-checking bench for ram_port_arbiter with a byte-array RAM
// responder and a transaction-level reference model.
module tb_ram_port_arbiter;
    import ram_arb_pkg::*;

    localparam int TMO = 8;
`ifdef RAM_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic        Clk, reset;
    logic        ifReq, ifDone, dsReq, dsRW, dsDone, busErr;
    logic [8:0]  ifAddr, dsAddr, ramAddress;
    logic [1:0]  dsSize, ramDataSize;
    logic [31:0] ifData, dsWData, dsRData, ramDataIn, ramDataOut;
    logic        ramMFA, ramRW, ramMFC;

    ram_port_arbiter #(.ADDR_W(9), .DATA_W(32), .TIMEOUT_CYC(TMO)) dut (
        .Clk(Clk), .reset(reset),
        .ifReq(ifReq), .ifAddr(ifAddr), .ifDone(ifDone), .ifData(ifData),
        .dsReq(dsReq), .dsRW(dsRW), .dsAddr(dsAddr), .dsSize(dsSize),
        .dsWData(dsWData), .dsDone(dsDone), .dsRData(dsRData), .busErr(busErr),
        .ramMFA(ramMFA), .ramRW(ramRW), .ramAddress(ramAddress),
        .ramDataSize(ramDataSize), .ramDataIn(ramDataIn),
        .ramDataOut(ramDataOut), .ramMFC(ramMFC)
    );

    always #5 Clk = ~Clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h at t=%0t", tag, got, exp, $time);
        end
    endtask

    typedef struct {
        logic [8:0]  addr;
        logic        rw;
        logic [1:0]  size;
        logic [31:0] wdata;
    } acc_t;

    acc_t       acc_q[$];
    logic [7:0] ram_mem[512];
    logic [7:0] shadow[512];
    int         cyc = 0;
    int         mfc_delay = 2;
    int         mfc_cyc = 0;
    int         mfa_cyc = 0;
    bit         last_is_ds = 1'b0;

    function automatic logic [31:0] pack_rd(input logic [1:0] sz, input logic [7:0] b0,
                                            input logic [7:0] b1, input logic [7:0] b2,
                                            input logic [7:0] b3);
        if (sz == 2'd0) return {24'h0, b0};
        if (sz == 2'd1) return {16'h0, b1, b0};
        return {b3, b2, b1, b0};
    endfunction

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    endfunction

    always @(posedge Clk) cyc++;

    // RAM responder: answers MFA after mfc_delay cycles (never if negative).
    int   wait_cnt = 0;
    int   low_run  = 100;
    bit   prev_mfa = 1'b0;
    bit   stable_ok;
    acc_t cap;
    always @(negedge Clk) begin
        acc_t e;
        int   a;
        if (ramMFA) begin
            if (!prev_mfa) begin
                check("mfa_gap", 32'(low_run >= 3), 1);
                check("mfa_expected", 32'(acc_q.size() > 0), 1);
                if (acc_q.size() > 0) begin
                    e = acc_q.pop_front();
                    check("ram_side", {ramAddress, ramRW, ramDataSize}, {e.addr, e.rw, e.size});
                    if (!e.rw) check("ram_wdata", ramDataIn, e.wdata);
                end
                cap = '{ramAddress, ramRW, ramDataSize, ramDataIn};
                stable_ok = 1'b1;
                wait_cnt = 0;
                mfa_cyc = cyc;
            end else if ({ramAddress, ramRW, ramDataSize, ramDataIn} !==
                         {cap.addr, cap.rw, cap.size, cap.wdata}) begin
                stable_ok = 1'b0;
            end
            if (mfc_delay >= 0 && wait_cnt == mfc_delay) begin
                ramMFC = 1'b1;
                mfc_cyc = cyc;
                a = int'(ramAddress);
                if (ramRW) begin
                    ramDataOut = pack_rd(ramDataSize, ram_mem[a], ram_mem[(a+1)%512],
                                         ram_mem[(a+2)%512], ram_mem[(a+3)%512]);
                end else begin
                    for (int i = 0; i < nbytes(ramDataSize); i++)
                        ram_mem[(a+i)%512] = ramDataIn[8*i +: 8];
                end
            end else begin
                ramMFC = 1'b0;
                ramDataOut = $urandom;
            end
            wait_cnt++;
            low_run = 0;
        end else begin
            if (prev_mfa) check("ram_stable", 32'(stable_ok), 1);
            ramMFC = 1'b0;
            low_run++;
        end
        prev_mfa = ramMFA;
    end

    task automatic run_txn(input bit use_if, input bit use_ds, input logic [8:0] ia,
                           input logic [8:0] da, input logic [1:0] dsz, input logic drw,
                           input logic [31:0] wd, input int dly);
        bit          ord[2];
        bit          e_err[2];
        int          e_kind[2];
        logic [31:0] e_data[2];
        int          n, k, a;
        bit          lg, to;
        mfc_delay = dly;
        if (use_if && use_ds) begin
            ord[0] = last_is_ds ? 1'b0 : 1'b1;
            ord[1] = ~ord[0];
            n = 2;
        end else begin
            ord[0] = use_ds;
            n = 1;
        end
        last_is_ds = ord[n-1];
        for (int j = 0; j < n; j++) begin
            if (!ord[j]) lg = (ia[1:0] == 2'b00);
            else lg = (dsz != 2'd3) && !(dsz == 2'd2 && da[1:0] != 2'b00) && !(dsz == 2'd1 && da[0]);
            to = lg && TO_EN && (dly < 0 || dly >= TMO);
            e_err[j]  = !lg || to;
            e_kind[j] = !lg ? 0 : (to ? 2 : 1);
            e_data[j] = '0;
            if (lg) begin
                if (!ord[j]) acc_q.push_back('{ia, 1'b1, 2'd2, 32'h0});
                else acc_q.push_back('{da, drw, dsz, wd});
            end
            if (lg && !to) begin
                a = !ord[j] ? int'(ia) : int'(da);
                if (!ord[j] || drw) begin
                    e_data[j] = pack_rd(!ord[j] ? 2'd2 : dsz, shadow[a], shadow[(a+1)%512],
                                        shadow[(a+2)%512], shadow[(a+3)%512]);
                end else begin
                    for (int i = 0; i < nbytes(dsz); i++) shadow[(a+i)%512] = wd[8*i +: 8];
                end
            end
        end
        @(negedge Clk);
        ifReq = use_if; ifAddr = ia;
        dsReq = use_ds; dsAddr = da; dsSize = dsz; dsRW = drw; dsWData = wd;
        repeat (2) @(posedge Clk);
        #1 check("first_latency", {ramMFA, ifDone | dsDone}, e_kind[0] == 0 ? 2'b01 : 2'b10);
        k = 0;
        for (int c = 0; c < 200 && k < n; c++) begin
            @(negedge Clk);
            if (ifDone || dsDone) begin
                check("done_id", {ifDone, dsDone}, ord[k] ? 2'b01 : 2'b10);
                check("busErr", busErr, e_err[k]);
                check("done_data", ord[k] ? dsRData : ifData, e_data[k]);
                if (e_kind[k] == 1) check("done_after_mfc", cyc, mfc_cyc + 1);
                if (e_kind[k] == 2) check("timeout_latency", cyc, mfa_cyc + TMO);
                if (ord[k]) dsReq = 1'b0; else ifReq = 1'b0;
                k++;
            end
        end
        check("txn_done_count", k, n);
        ifReq = 1'b0; dsReq = 1'b0;
        @(negedge Clk);
    endtask

    task automatic reset_mid_access();
        int seen;
        mfc_delay = -1;
        acc_q.push_back('{9'h040, 1'b1, 2'd2, 32'h0});
        @(negedge Clk);
        ifReq = 1'b1; ifAddr = 9'h040;
        for (int c = 0; c < 10 && !ramMFA; c++) @(negedge Clk);
        check("rst_mfa_up", ramMFA, 1);
        @(negedge Clk);
        #2 reset = 1'b0;
        #1 check("rst_async", {ramMFA, ifDone, dsDone, busErr}, 0);
        ifReq = 1'b0;
        acc_q.delete();
        @(negedge Clk);
        reset = 1'b1;
        last_is_ds = 1'b0;
        seen = 0;
        repeat (4) begin
            @(negedge Clk);
            if (ifDone || dsDone || ramMFA) seen++;
        end
        check("rst_no_done", seen, 0);
        mfc_delay = 2;
    endtask

    initial begin
        logic [8:0] ia, da;
        logic [1:0] sz;
        int         r, dly;
        Clk = 0; reset = 0; ramMFC = 0; ramDataOut = '0;
        ifReq = 0; ifAddr = '0; dsReq = 0; dsRW = 0; dsAddr = '0; dsSize = '0; dsWData = '0;
        for (int i = 0; i < 512; i++) begin
            ram_mem[i] = 8'($urandom);
            shadow[i]  = ram_mem[i];
        end
        {ram_mem[16], ram_mem[17], ram_mem[18], ram_mem[19]} = 32'hEFBEADDE;
        {shadow[16], shadow[17], shadow[18], shadow[19]} = 32'hEFBEADDE;
        repeat (2) @(posedge Clk);
        #1 check("reset_ctrl", {ifDone, dsDone, busErr, ramMFA, ramRW, ramAddress, ramDataSize}, 0);
        check("reset_data", ifData | dsRData | ramDataIn, 0);
        @(negedge Clk) reset = 1'b1;

        run_txn(1, 0, 9'h010, 9'h000, 2'd0, 1'b1, 32'h0, 3);
        check("fetch_deadbeef", ifData, 32'hDEADBEEF);
        run_txn(0, 1, 9'h000, 9'h020, 2'd2, 1'b0, 32'h12345678, 2);
        run_txn(0, 1, 9'h000, 9'h020, 2'd2, 1'b1, 32'h0, 1);
        run_txn(0, 1, 9'h000, 9'h021, 2'd0, 1'b1, 32'h0, 0);
        run_txn(0, 1, 9'h000, 9'h022, 2'd1, 1'b1, 32'h0, 0);
        run_txn(0, 1, 9'h000, 9'h022, 2'd2, 1'b1, 32'h0, 2);
        run_txn(0, 1, 9'h000, 9'h023, 2'd1, 1'b0, 32'hAAAA5555, 2);
        run_txn(0, 1, 9'h000, 9'h020, 2'd3, 1'b1, 32'h0, 2);
        run_txn(1, 0, 9'h011, 9'h000, 2'd0, 1'b1, 32'h0, 2);
        run_txn(1, 0, 9'h010, 9'h000, 2'd0, 1'b1, 32'h0, 12);
`ifdef RAM_TIMEOUT_EN
        run_txn(1, 0, 9'h010, 9'h000, 2'd0, 1'b1, 32'h0, -1);
`endif
        reset_mid_access();
        repeat (4) begin
            ia = 9'($urandom_range(0, 15) * 4);
            da = 9'($urandom_range(0, 15) * 4);
            run_txn(1, 1, ia, da, 2'd2, 1'($urandom), $urandom, $urandom_range(0, 3));
        end
        repeat (60) begin
            r  = $urandom_range(1, 3);
            ia = 9'($urandom_range(0, 15) * 4);
            if ($urandom_range(0, 9) == 0) ia[1:0] = 2'($urandom);
            sz = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            da = 9'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) da = da & ~9'(nbytes(sz) - 1);
            dly = ($urandom_range(0, 11) == 0) ? 9 : $urandom_range(0, 4);
            run_txn(r[0], r[1], ia, da, sz, 1'($urandom), $urandom, dly);
        end
        check("acc_queue_empty", acc_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
